// File: rtl/fft_vec_rr_scheduler_pkg.sv
// Shared constants for the FFT vector round-robin scheduler: FSM encodings and
// the index-width helper used to size the source tag and beat counter.
package fft_sched_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_SERIAL = 1'b1;

  // Width of an index into n items; never below 1 so single-entry ranges still get a bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_vec_rr_scheduler_if.sv
// Requester and downstream handshake bundle. The slave modport is the scheduler's
// view; the master modport is the view of the requesters plus the downstream sink.
interface fft_vec_rr_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int N_REQ = 4
);
  import fft_sched_pkg::*;

  localparam int SRC_W = idx_w(N_REQ);

  logic [N_REQ-1:0]                         req_valid;
  logic [N_REQ-1:0]                         req_ready;
  logic [N_REQ-1:0][DEPTH-1:0][WIDTH-1:0]   req_data;

  logic                                     down_valid;
  logic                                     down_ready;
  logic [WIDTH-1:0]                         down_data;
  logic [SRC_W-1:0]                         down_src;
  logic                                     down_last;

  modport master (
    output req_valid,
    output req_data,
    output down_ready,
    input  req_ready,
    input  down_valid,
    input  down_data,
    input  down_src,
    input  down_last
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  down_ready,
    output req_ready,
    output down_valid,
    output down_data,
    output down_src,
    output down_last
  );

endinterface

// File: rtl/fft_vec_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Holds no state; the owner keeps the pointer.
module rr_arbiter
  import fft_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any     = 1'b1;
        gnt_idx = PW'((int'(ptr) + k) % N);
      end
    end
    gnt = any ? (ONE << gnt_idx) : '0;
  end

endmodule

// File: rtl/fft_vec_rr_scheduler.sv
// Shares one vector-to-stream serializer between N_REQ requesters: grants a whole
// vector round-robin, latches it, and streams it word by word tagged with source/last.
module fft_vec_rr_scheduler
  import fft_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  arstn,
  fft_vec_rr_scheduler_if.slave bus,
  output logic                  busy
);

  localparam int SRC_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N_REQ - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q,   cnt_d;
  logic [SRC_W-1:0]            src_q,   src_d;
  logic [SRC_W-1:0]            ptr_q,   ptr_d;
  logic [DEPTH-1:0][WIDTH-1:0] vbuf_q,  vbuf_d;

  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             any;
  logic             serial;
  logic             at_last;
  logic             load_ok;
  logic             load;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign serial  = (state_q == ST_SERIAL);
  assign at_last = (cnt_q == CNT_LAST);

  // Loading on the final beat's handshake is what removes the bubble between vectors.
  assign load_ok = !serial || (at_last && bus.down_ready);
  assign load    = load_ok && any;

  // Gated by arstn directly so no grant can leak out while reset is held.
  assign bus.req_ready = (arstn && load) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    vbuf_d  = vbuf_q;
    if (load) begin
      vbuf_d  = bus.req_data[gnt_idx];
      src_d   = gnt_idx;
      cnt_d   = '0;
      ptr_d   = (gnt_idx == SRC_LAST) ? '0 : gnt_idx + 1'b1;
      state_d = ST_SERIAL;
    end else if (serial && bus.down_ready) begin
      if (!at_last) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      vbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      vbuf_q  <= vbuf_d;
    end
  end

  // cnt stays on the last word after a vector ends, so data/src hold their final values in IDLE.
  assign bus.down_valid = serial;
  assign bus.down_data  = vbuf_q[cnt_q];
  assign bus.down_src   = src_q;
  assign bus.down_last  = serial && at_last;
  assign busy           = serial;

endmodule

// File: tb/tb_fft_vec_rr_scheduler.sv
// Self-checking bench for fft_vec_rr_scheduler: queue-based behavioural model,
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_fft_vec_rr_scheduler;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int N_REQ = 4;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  logic busy;

  fft_vec_rr_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) bus ();

  fft_vec_rr_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: the held vector is a queue of words still to send.
  bit          m_busy = 1'b0;
  int unsigned m_q[$];
  int          m_src  = 0;
  int          m_ptr  = 0;
  int unsigned m_hold = 0;
  logic [N_REQ-1:0] m_rdy = '0;

  function automatic int m_winner();
    for (int k = 0; k < N_REQ; k++) begin
      int j = (m_ptr + k) % N_REQ;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] m_ready();
    logic [N_REQ-1:0] one = 1;
    int w = m_winner();
    bit ok = !m_busy || (m_q.size() == 1 && bus.down_ready);
    if (!arstn || !ok || w < 0) return '0;
    return one << w;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0;
    m_q.delete();
    m_src  = 0;
    m_ptr  = 0;
    m_hold = 0;
  endtask

  task automatic m_step();
    int w = m_winner();
    logic [N_REQ-1:0] r = m_ready();
    if (m_busy && bus.down_ready) m_hold = m_q.pop_front();
    if (r != '0) begin
      m_q.delete();
      for (int d = 0; d < DEPTH; d++) m_q.push_back(int'(bus.req_data[w][d]));
      m_src  = w;
      m_ptr  = (w + 1) % N_REQ;
      m_busy = 1'b1;
    end else if (m_q.size() == 0) begin
      m_busy = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge arstn);
    if (!arstn) m_reset();
    else        m_step();
  end

  // Logs of what the DUT actually did, for literal expectations.
  typedef struct {
    int unsigned data;
    int          src;
    bit          last;
    int          cyc;
  } beat_t;
  beat_t beats[$];
  int    grants[$];

  task automatic compare_cycle();
    logic [N_REQ-1:0] er = m_ready();
    m_rdy = er;
    chk("req_ready",  bus.req_ready,  er);
    chk("down_valid", bus.down_valid, m_busy);
    chk("busy",       busy,           m_busy);
    chk("down_src",   bus.down_src,   m_src);
    chk("down_last",  bus.down_last,  m_busy && m_q.size() == 1);
    if (m_busy) chk("down_data", bus.down_data, m_q[0]);
    else        chk("down_data_hold", bus.down_data, m_hold);
    if (arstn && bus.down_valid && bus.down_ready)
      beats.push_back('{int'(bus.down_data), int'(bus.down_src), bus.down_last, cyc});
    for (int i = 0; i < N_REQ; i++)
      if (arstn && bus.req_ready[i]) grants.push_back(i);
  endtask

  initial forever begin
    @(negedge clk);
    compare_cycle();
  end

  // Stimulus driver
  logic [N_REQ-1:0] persist = '0;

  task automatic set_vec(input int i, input int w0, input int w1, input int w2, input int w3);
    bus.req_data[i][0] = WIDTH'(w0);
    bus.req_data[i][1] = WIDTH'(w1);
    bus.req_data[i][2] = WIDTH'(w2);
    bus.req_data[i][3] = WIDTH'(w3);
    bus.req_valid[i]   = 1'b1;
  endtask

  task automatic rand_vec(input int i);
    set_vec(i, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
  endtask

  task automatic tick();
    logic [N_REQ-1:0] granted;
    @(posedge clk);
    granted = m_rdy;
    #1;
    cyc++;
    for (int i = 0; i < N_REQ; i++) begin
      if (granted[i]) begin
        if (persist[i]) rand_vec(i);
        else            bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    beats.delete();
    grants.delete();
  endtask

  task automatic do_reset(input int n);
    arstn = 1'b0;
    repeat (n) tick();
    arstn = 1'b1;
    clear_logs();
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.down_ready = 1'b1;

    // Reset held with every requester asking
    for (int i = 0; i < N_REQ; i++) rand_vec(i);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("rst_req_ready",  bus.req_ready,  0);
      chk("rst_down_valid", bus.down_valid, 0);
      chk("rst_down_data",  bus.down_data,  0);
      chk("rst_busy",       busy,           0);
    end
    bus.req_valid = '0;
    arstn = 1'b1;
    tick();
    clear_logs();

    // Single vector
    set_vec(0, 1, 2, 3, 4);
    repeat (7) tick();
    chk("single_grants", grants.size(), 1);
    if (grants.size() == 1) chk("single_grant_idx", grants[0], 0);
    chk("single_beats", beats.size(), 4);
    if (beats.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        chk("single_data", beats[b].data, b + 1);
        chk("single_src",  beats[b].src,  0);
        chk("single_last", beats[b].last, b == 3);
      end
      chk("single_span", beats[3].cyc - beats[0].cyc, 3);
    end
    chk("single_idle", bus.down_valid, 0);

    // Contention: all four at once
    do_reset(1);
    for (int k = 0; k < N_REQ; k++) set_vec(k, 10*k, 10*k + 1, 10*k + 2, 10*k + 3);
    repeat (20) tick();
    chk("cont_grants", grants.size(), 4);
    if (grants.size() == 4)
      for (int g = 0; g < 4; g++) chk("cont_grant_order", grants[g], g);
    chk("cont_beats", beats.size(), 16);
    if (beats.size() == 16) begin
      for (int b = 0; b < 16; b++) begin
        chk("cont_data", beats[b].data, 10*(b/4) + b%4);
        chk("cont_src",  beats[b].src,  b/4);
        chk("cont_last", beats[b].last, (b % 4) == 3);
      end
      chk("cont_no_bubble", beats[15].cyc - beats[0].cyc, 15);
    end

    // Backpressure: ready alternating
    do_reset(1);
    set_vec(0, 5, 6, 7, 8);
    for (int t = 0; t < 12; t++) begin
      bus.down_ready = t[0];
      tick();
    end
    bus.down_ready = 1'b1;
    chk("bp_grants", grants.size(), 1);
    chk("bp_beats", beats.size(), 4);
    if (beats.size() == 4) begin
      for (int b = 0; b < 4; b++) chk("bp_data", beats[b].data, b + 5);
      chk("bp_span", beats[3].cyc - beats[0].cyc, 6);
    end

    // Fairness between two always-valid requesters
    do_reset(1);
    persist = 4'b0101;
    rand_vec(0);
    rand_vec(2);
    repeat (40) tick();
    persist = '0;
    bus.req_valid = '0;
    repeat (8) tick();
    chk("fair_min_grants", grants.size() >= 8, 1);
    for (int g = 0; g < grants.size(); g++) chk("fair_grant", grants[g], (g % 2) * 2);
    chk("fair_beats", beats.size(), 4 * grants.size());
    for (int b = 0; b < beats.size(); b++) chk("fair_src", beats[b].src, ((b/4) % 2) * 2);

    // Reset in the middle of a vector
    do_reset(1);
    set_vec(0, 1, 2, 3, 4);
    for (int t = 0; t < 10 && beats.size() < 2; t++) tick();
    chk("mid_two_beats", beats.size(), 2);
    arstn = 1'b0;
    #1;
    chk("mid_valid_drop", bus.down_valid, 0);
    chk("mid_data_clr",   bus.down_data,  0);
    chk("mid_busy_clr",   busy,           0);
    bus.req_valid = '0;
    tick();
    tick();
    clear_logs();
    arstn = 1'b1;
    set_vec(1, 9, 9, 9, 9);
    repeat (7) tick();
    chk("mid_grants", grants.size(), 1);
    if (grants.size() == 1) chk("mid_grant_idx", grants[0], 1);
    chk("mid_beats", beats.size(), 4);
    if (beats.size() == 4)
      for (int b = 0; b < 4; b++) begin
        chk("mid_data", beats[b].data, 9);
        chk("mid_src",  beats[b].src,  1);
        chk("mid_last", beats[b].last, b == 3);
      end

    // Random traffic with drops and backpressure
    do_reset(1);
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom_range(2) == 0) rand_vec(i);
        end else if ($urandom_range(19) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.down_ready = ($urandom_range(3) != 0);
      tick();
    end
    bus.req_valid  = '0;
    bus.down_ready = 1'b1;
    repeat (8) tick();
    chk("rand_some_grants", grants.size() > 100, 1);
    chk("rand_beats", beats.size(), 4 * grants.size());
    chk("rand_drained", bus.down_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
